// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier.
module alu_muldiv_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [5:0]  ALUCtrl,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivByZero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [5:0] OP_MTHI = 6'h11;
  localparam logic [5:0] OP_MTLO = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d, b_zero_q, b_zero_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes; bit 0 of the opcode distinguishes unsigned variants
  logic           op_signed, a_neg, b_neg, is_muldiv;
  logic [W-1:0]   a_abs, b_abs;
  assign is_muldiv = (ALUCtrl[5:2] == 4'b0110);
  assign op_signed = ~ALUCtrl[0];
  assign a_neg     = op_signed & A[W-1];
  assign b_neg     = op_signed & B[W-1];
  assign a_abs     = a_neg ? W'(-A) : A;
  assign b_abs     = b_neg ? W'(-B) : B;

  // Datapath steps and sign correction
  logic [W:0]     mul_sum, div_diff;
  logic           res_neg;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, a_orig;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : (W+1)'(0));
  assign div_diff = acc_q[2*W-1:W-1] - {1'b0, opb_q};
  assign res_neg  = sign_a_q ^ sign_b_q;
  assign prod_fix = res_neg ? (2*W)'(-acc_q) : acc_q;
  assign quot_fix = res_neg ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
  assign rem_fix  = sign_a_q ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
  assign a_orig   = sign_a_q ? W'(-opa_q) : opa_q;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = (2*W)'(a_abs) * (2*W)'(b_abs);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (Start && is_muldiv) begin
          opa_d    = a_abs;
          opb_d    = b_abs;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          is_div_d = ALUCtrl[1];
          b_zero_d = (B == '0);
          cnt_d    = CW'(W);
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          if (ALUCtrl[1]) begin
            acc_d   = {{W{1'b0}}, a_abs};
            state_d = S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = fast_prod;
            cnt_d   = '0;
            state_d = S_FIX;
`else
            acc_d   = {{W{1'b0}}, b_abs};
            state_d = S_MUL;
`endif
          end
        end else if (Start && ALUCtrl == OP_MTHI) begin
          hi_d  = A;
          dbz_d = 1'b0;
        end else if (Start && ALUCtrl == OP_MTLO) begin
          lo_d  = A;
          dbz_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = CW'(cnt_q - 1'b1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        // Restoring step: keep the trial subtraction only when it does not underflow
        if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        else              acc_d = {acc_q[2*W-2:0], 1'b0};
        cnt_d = CW'(cnt_q - 1'b1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q && b_zero_q) begin
          hi_d  = a_orig;
          lo_d  = {W{1'b1}};
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: arithmetic reference model checked every cycle plus literal vectors.
module tb_alu_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [5:0]  ALUCtrl = '0;
  logic        Start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  alu_muldiv_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .ALUCtrl(ALUCtrl), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {dbz, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model_res(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model_res = '0;
    case (op)
      6'h18: begin p = 64'(sa * sb); model_res = {1'b0, p}; end
      6'h19: begin p = ua * ub; model_res = {1'b0, p}; end
      6'h1A, 6'h1B: begin
        if (b == 32'd0) model_res = {1'b1, a, 32'hFFFFFFFF};
        else if (op == 6'h1A) begin
          q = sa / sb; r = sa % sb;
          model_res = {1'b0, 32'(r), 32'(q)};
        end else begin
          p = ua / ub; ub = ua % ub;
          model_res = {1'b0, ub[31:0], p[31:0]};
        end
      end
      default: model_res = '0;
    endcase
  endfunction

  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] p_res;
  int          m_rem;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_rem <= 0; p_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= p_res[63:32]; m_lo <= p_res[31:0]; m_dbz <= p_res[64];
        end
      end else if (Start) begin
        if (ALUCtrl inside {[6'h18:6'h1B]}) begin
          m_busy <= 1'b1; m_dbz <= 1'b0;
          p_res <= model_res(ALUCtrl, A, B);
          m_rem <= (ALUCtrl[1] == 1'b0) ? MUL_LAT : DIV_LAT;
        end else if (ALUCtrl == 6'h11) begin
          m_hi <= A; m_dbz <= 1'b0;
        end else if (ALUCtrl == 6'h13) begin
          m_lo <= A; m_dbz <= 1'b0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(Busy), 32'(m_busy));
      chk("cyc_done", 32'(Done), 32'(m_done));
      chk("cyc_dbz",  32'(DivByZero), 32'(m_dbz));
      chk("cyc_hi",   Hi, m_hi);
      chk("cyc_lo",   Lo, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int n;
    n = 0;
    ALUCtrl = op; A = a; B = b; Start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      if (i == 1) Start = 1'b0;
      n = i;
      if (Done === 1'b1) break;
    end
    chk({name, "_lat"}, 32'(n), 32'(lat + 1));
    chk({name, "_hi"}, Hi, ehi);
    chk({name, "_lo"}, Lo, elo);
    chk({name, "_dbz"}, 32'(DivByZero), 32'(edbz));
    @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    run_op("mult_m2x7",  6'h18, 32'hFFFFFFFE, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0);
    run_op("multu_m2x7", 6'h19, 32'hFFFFFFFE, 32'd7, MUL_LAT, 32'd6, 32'hFFFFFFF2, 1'b0);
    run_op("mult_3xm4",  6'h18, 32'd3, 32'hFFFFFFFC, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);
    run_op("div_m7d2",   6'h1A, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_100d7", 6'h1B, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);

    ALUCtrl = 6'h11; A = 32'h12345678; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("mthi_hi", Hi, 32'h12345678);
    chk("mthi_busy", 32'(Busy), 32'd0);
    ALUCtrl = 6'h13; A = 32'h9ABCDEF0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("mtlo_lo", Lo, 32'h9ABCDEF0);
    chk("mtlo_hi", Hi, 32'h12345678);
    chk("mtlo_busy", 32'(Busy), 32'd0);

    ALUCtrl = 6'h00; A = 32'hDEADBEEF; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("noop_busy", 32'(Busy), 32'd0);
    chk("noop_hi", Hi, 32'h12345678);

    // A second Start during a busy DIVU must be dropped
    begin
      int n;
      n = 0;
      ALUCtrl = 6'h1B; A = 32'd1000; B = 32'd7; Start = 1'b1;
      for (int i = 1; i <= 60; i++) begin
        @(negedge Clk);
        Start = 1'b0;
        if (i == 4) begin ALUCtrl = 6'h1A; A = 32'hFFFFFFF9; B = 32'd2; Start = 1'b1; end
        if (i == 10) begin
          chk("ign_hi", Hi, 32'h12345678);
          chk("ign_lo", Lo, 32'h9ABCDEF0);
        end
        n = i;
        if (Done === 1'b1) break;
      end
      chk("ign_lat", 32'(n), 32'(DIV_LAT + 1));
      chk("ign_res_lo", Lo, 32'd142);
      chk("ign_res_hi", Hi, 32'd6);
      repeat (3) @(negedge Clk);
      chk("ign_no_restart", 32'(Busy), 32'd0);
    end

    run_op("divu_5d0",   6'h1B, 32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf",    6'h1A, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'd0, 32'h80000000, 1'b0);

    // Asynchronous reset ten cycles into a MULT
    ALUCtrl = 6'h18; A = 32'd7; B = 32'd9; Start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    chk("arst_hi", Hi, 32'd0);
    chk("arst_lo", Lo, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    run_op("post_rst_multu", 6'h19, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12, 1'b0);
    repeat (40) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
